layer_compositor: RTL and testbench
===================================

Name: layer_compositor

Overview:
- Parametrised successor to the single-overlay colorizer. Composites NUM_LAYERS prioritised RGB icon layers over a palette-mapped world map and a backdrop pixel.
- Sits between the DTG/icon/map ROM outputs and the VGA pins.
- Fixed 2-cycle pipeline.
- Runtime-writable world palette; optional per-layer blink.

Parameters:
- NUM_LAYERS, 2, number of overlay layers; layer 0 has the highest priority.
- COLOR_W, 12, packed colour width; must be divisible by 3. Packing is {blue, green, red}, with red in the LSBs.
- WORLD_W, 2, world-map pixel index width; the palette has 2^WORLD_W entries.
- BLINK_DIV_W, 5, width of the blink frame counter; the blink phase is the counter MSB.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high.
- video_on  in  1  DTG display-enable, aligned with the pixel inputs.
- world_pixel  in  WORLD_W  world-map index.
- layer_pixels  in  NUM_LAYERS*(COLOR_W+1)  layer i occupies bits [i*(COLOR_W+1) +: COLOR_W+1]; its MSB is the opaque flag.
- bg_pixel  in  COLOR_W  backdrop colour, shown where the world index is 0.
- pal_we  in  1  palette write strobe.
- pal_addr  in  WORLD_W  palette write address.
- pal_wdata  in  COLOR_W  palette write data.
- frame_start  in  1  one-cycle pulse per frame; used only when BLINK_EN is defined.
- blink_mask  in  NUM_LAYERS  per-layer blink enable; used only when BLINK_EN is defined.
- vga_red  out  COLOR_W/3  red intensity.
- vga_green  out  COLOR_W/3  green intensity.
- vga_blue  out  COLOR_W/3  blue intensity.
- layer_hit  out  NUM_LAYERS  one-hot index of the winning layer; all zero when no layer wins (world or backdrop shown).

Behaviour:
- Reset:
  - vga_red, vga_green, vga_blue = 0; layer_hit = 0.
  - Pipeline valid/video bits cleared.
  - Palette restored to 0:0x000, 1:0xC66, 2:0x1AD, 3:0x000. For WORLD_W>2, entries 4 and up reset to 0.
  - Blink counter = 0.
- Stage 1 (cycle N+1): register video_on, world_pixel, layer_pixels, bg_pixel.
- Stage 2 (cycle N+2): resolve and register the outputs. Latency is exactly 2 clocks from input to pins; throughput is 1 pixel/clk.
- Resolve order:
  - If stage-1 video_on = 0: output 0, layer_hit = 0.
  - Else the lowest-index layer with opaque=1 (and not blanked by blink) wins; output its colour and set its layer_hit bit.
  - Else if world index = 0: output bg_pixel.
  - Else output palette[world index].
- Palette:
  - Register array, read combinationally in stage 2.
  - A write is visible to the read starting the cycle after pal_we.
  - A write coinciding with a stage-2 read of the same address returns the old value.
  - Writes are accepted regardless of video_on.
- Reset asserted mid-frame: the next clock zeroes the outputs. The first valid output appears 2 clocks after reset deasserts.
- Several opaque layers at once: strict priority, never blended.
- All-transparent with index 3 (reset palette): black.

Optional Feature:
- Macro: LAYER_COMPOSITOR_BLINK_EN.
- With the macro defined:
  - A BLINK_DIV_W-bit counter increments on each frame_start and wraps at all-ones back to 0.
  - When the counter MSB = 1, any layer whose blink_mask bit is 1 is treated as transparent.
  - The blink_mask sample is registered in stage 1 alongside the pixel data.
  - frame_start during reset is ignored.
- Without the macro: no counter is built, frame_start and blink_mask are unused, and layers are never blanked.

Decomposition:
- Package compositor_pkg holds:
  - Colour field offsets (RED_LSB=0, GRN_LSB=COLOR_W/3, BLU_LSB=2*COLOR_W/3).
  - Default palette constants PAL_BG, PAL_TRAIL=0xC66, PAL_OBST=0x1AD.
  - The opaque-flag position function.
- One sub-module, world_palette: register file with reset defaults, a write port and a combinational read port.

Test Plan:
- Reset, then video_on=1, world=1, all layers transparent → after 2 clks, R=6 G=6 B=C; layer_hit=0.
- world=2, layer1 = opaque 0x0F0, layer0 transparent → G=F, R=0, B=0; layer_hit=2'b10. Then make layer0 opaque 0x00E as well → R=E, layer_hit=2'b01.
- Palette collision: pal_we with addr 1, data 0x123, in the same cycle stage 2 reads index 1 → that pixel shows 0xC66; the next pixel shows R=3 G=2 B=1.
- Blanking: video_on=0 with an opaque layer → all outputs 0. Reset pulsed mid-stream → outputs 0 next clk, and the palette reverts to 0xC66 at index 1.
- world=0, bg_pixel=0x4A7 → R=7 G=A B=4.
- LAYER_COMPOSITOR_BLINK_EN: blink_mask=2'b01, layer0 opaque, 16 frame_start pulses (BLINK_DIV_W=5, counter MSB=1) → layer0 hidden, world colour shown. After 32 pulses the counter wraps and layer0 is shown again.

Source files
------------

// File: rtl/layer_compositor_pkg.sv
// rtl/layer_compositor_pkg.sv - shared constants and helpers for layer_compositor
//
// Package compositor_pkg:
//   DEF_*           default parameter values for the compositor and its interface
//   RED/GRN/BLU_LSB colour field offsets inside a packed {blue, green, red} pixel
//   PAL_*           world palette reset colours (12-bit {b,g,r})
//   opaque_pos()    bit position of a layer's opaque flag in the packed layer bus
//   chan_lsb()      LSB of colour channel 0/1/2 (red/green/blue) for any colour width
package compositor_pkg;

  localparam int DEF_NUM_LAYERS  = 2;
  localparam int DEF_COLOR_W     = 12;
  localparam int DEF_WORLD_W     = 2;
  localparam int DEF_BLINK_DIV_W = 5;

  localparam int CH_RED = 0;
  localparam int CH_GRN = 1;
  localparam int CH_BLU = 2;

  localparam int RED_LSB = 0;
  localparam int GRN_LSB = DEF_COLOR_W / 3;
  localparam int BLU_LSB = 2 * DEF_COLOR_W / 3;

  localparam logic [11:0] PAL_BG    = 12'h000;
  localparam logic [11:0] PAL_TRAIL = 12'hC66;
  localparam logic [11:0] PAL_OBST  = 12'h1AD;

  // Each layer is COLOR_W colour bits followed by its opaque flag.
  function automatic int opaque_pos(int layer, int color_w);
    return layer * (color_w + 1) + color_w;
  endfunction

  function automatic int chan_lsb(int chan, int color_w);
    return chan * (color_w / 3);
  endfunction

endpackage

// File: rtl/layer_compositor_if.sv
// rtl/layer_compositor_if.sv - pixel, palette-write and VGA signal bundle for layer_compositor
//
// master: the pixel source (DTG / ROM side) driving pixels and palette writes
// slave : the compositor, consuming pixels and driving the VGA pins
// Signals: video_on, world_pixel, layer_pixels, bg_pixel, pal_we, pal_addr,
//          pal_wdata, frame_start, blink_mask (to compositor);
//          vga_red, vga_green, vga_blue, layer_hit (from compositor)
interface layer_compositor_if
  import compositor_pkg::*;
#(
  parameter int NUM_LAYERS = DEF_NUM_LAYERS,
  parameter int COLOR_W    = DEF_COLOR_W,
  parameter int WORLD_W    = DEF_WORLD_W
);

  logic                                video_on;
  logic [WORLD_W-1:0]                  world_pixel;
  logic [NUM_LAYERS*(COLOR_W+1)-1:0]   layer_pixels;
  logic [COLOR_W-1:0]                  bg_pixel;
  logic                                pal_we;
  logic [WORLD_W-1:0]                  pal_addr;
  logic [COLOR_W-1:0]                  pal_wdata;
  logic                                frame_start;
  logic [NUM_LAYERS-1:0]               blink_mask;
  logic [COLOR_W/3-1:0]                vga_red;
  logic [COLOR_W/3-1:0]                vga_green;
  logic [COLOR_W/3-1:0]                vga_blue;
  logic [NUM_LAYERS-1:0]               layer_hit;

  modport master (
    output video_on, world_pixel, layer_pixels, bg_pixel,
    output pal_we, pal_addr, pal_wdata, frame_start, blink_mask,
    input  vga_red, vga_green, vga_blue, layer_hit
  );

  modport slave (
    input  video_on, world_pixel, layer_pixels, bg_pixel,
    input  pal_we, pal_addr, pal_wdata, frame_start, blink_mask,
    output vga_red, vga_green, vga_blue, layer_hit
  );

endinterface

// File: rtl/layer_compositor_palette.sv
// rtl/layer_compositor_palette.sv - world palette register file with reset defaults
//
// Module world_palette:
//   clk, reset      clock, synchronous active-high reset (restores default colours)
//   we/waddr/wdata  write port, committed on the clock edge
//   raddr/rdata     combinational read port; a same-cycle write is not yet visible
module world_palette
  import compositor_pkg::*;
#(
  parameter int COLOR_W = DEF_COLOR_W,
  parameter int WORLD_W = DEF_WORLD_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               we,
  input  logic [WORLD_W-1:0] waddr,
  input  logic [COLOR_W-1:0] wdata,
  input  logic [WORLD_W-1:0] raddr,
  output logic [COLOR_W-1:0] rdata
);

  localparam int DEPTH = 1 << WORLD_W;

  logic [COLOR_W-1:0] mem [DEPTH];

  function automatic logic [COLOR_W-1:0] reset_value(int idx);
    case (idx)
      1:       return COLOR_W'(PAL_TRAIL);
      2:       return COLOR_W'(PAL_OBST);
      default: return COLOR_W'(PAL_BG);
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= reset_value(i);
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/layer_compositor.sv
// rtl/layer_compositor.sv - prioritised icon layers over a palette-mapped world map, 2-cycle pipeline
//
// Ports:
//   clk    system clock
//   reset  synchronous, active-high; clears pipeline, outputs, palette, blink counter
//   bus    layer_compositor_if.slave: pixel inputs, palette write port, blink
//          controls in; vga_red/green/blue and one-hot layer_hit out
// Stage 1 registers the pixel inputs; stage 2 resolves layer priority, world
// palette and backdrop, and registers the VGA outputs.
// Optional macro LAYER_COMPOSITOR_BLINK_EN builds the per-frame blink counter;
// without it frame_start and blink_mask are ignored.
module layer_compositor
  import compositor_pkg::*;
#(
  parameter int NUM_LAYERS  = DEF_NUM_LAYERS,
  parameter int COLOR_W     = DEF_COLOR_W,
  parameter int WORLD_W     = DEF_WORLD_W,
  parameter int BLINK_DIV_W = DEF_BLINK_DIV_W
) (
  input  logic              clk,
  input  logic              reset,
  layer_compositor_if.slave bus
);

  localparam int CH_W    = COLOR_W / 3;
  localparam int LAYER_W = COLOR_W + 1;
  localparam int R_LSB   = chan_lsb(CH_RED, COLOR_W);
  localparam int G_LSB   = chan_lsb(CH_GRN, COLOR_W);
  localparam int B_LSB   = chan_lsb(CH_BLU, COLOR_W);

  // Stage 1 registers
  logic                          s1_video;
  logic [WORLD_W-1:0]            s1_world;
  logic [NUM_LAYERS*LAYER_W-1:0] s1_layers;
  logic [COLOR_W-1:0]            s1_bg;

  // Stage 2 (output) registers
  logic [COLOR_W-1:0]            out_color;
  logic [NUM_LAYERS-1:0]         out_hit;

  logic [COLOR_W-1:0]            pal_rdata;
  logic [NUM_LAYERS-1:0]         layer_blank;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_video  <= 1'b0;
      s1_world  <= '0;
      s1_layers <= '0;
      s1_bg     <= '0;
    end else begin
      s1_video  <= bus.video_on;
      s1_world  <= bus.world_pixel;
      s1_layers <= bus.layer_pixels;
      s1_bg     <= bus.bg_pixel;
    end
  end

  world_palette #(
    .COLOR_W (COLOR_W),
    .WORLD_W (WORLD_W)
  ) u_palette (
    .clk   (clk),
    .reset (reset),
    .we    (bus.pal_we),
    .waddr (bus.pal_addr),
    .wdata (bus.pal_wdata),
    .raddr (s1_world),
    .rdata (pal_rdata)
  );

`ifdef LAYER_COMPOSITOR_BLINK_EN
  logic [BLINK_DIV_W-1:0] blink_cnt;
  logic [NUM_LAYERS-1:0]  s1_blink_mask;

  always_ff @(posedge clk) begin
    if (reset) begin
      blink_cnt     <= '0;
      s1_blink_mask <= '0;
    end else begin
      if (bus.frame_start) begin
        blink_cnt <= blink_cnt + 1'b1;
      end
      s1_blink_mask <= bus.blink_mask;
    end
  end

  // Blink phase is the counter MSB: half of every 2^BLINK_DIV_W frames hidden.
  assign layer_blank = blink_cnt[BLINK_DIV_W-1] ? s1_blink_mask : '0;
`else
  logic unused_blink;
  assign unused_blink = ^{bus.frame_start, bus.blink_mask, BLINK_DIV_W[0]};
  assign layer_blank  = '0;
`endif

  // Priority chain: a layer takes the pixel only if no lower-index layer did,
  // so take[] is one-hot and the colour can be OR-accumulated without muxes.
  logic [NUM_LAYERS:0]   none_above;
  logic [NUM_LAYERS-1:0] take;
  logic [COLOR_W-1:0]    color_acc [NUM_LAYERS+1];

  assign none_above[0] = 1'b1;
  assign color_acc[0]  = '0;

  for (genvar g = 0; g < NUM_LAYERS; g++) begin : g_layer
    logic               opaque;
    logic [COLOR_W-1:0] color;

    assign opaque          = s1_layers[opaque_pos(g, COLOR_W)];
    assign color           = s1_layers[g*LAYER_W +: COLOR_W];
    assign take[g]         = opaque & ~layer_blank[g] & none_above[g];
    assign none_above[g+1] = none_above[g] & ~take[g];
    assign color_acc[g+1]  = color_acc[g] | ({COLOR_W{take[g]}} & color);
  end

  logic [COLOR_W-1:0]    next_color;
  logic [NUM_LAYERS-1:0] next_hit;

  always_comb begin
    next_color = '0;
    next_hit   = '0;
    if (s1_video) begin
      if (!none_above[NUM_LAYERS]) begin
        next_color = color_acc[NUM_LAYERS];
        next_hit   = take;
      end else if (s1_world == '0) begin
        next_color = s1_bg;
      end else begin
        next_color = pal_rdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_color <= '0;
      out_hit   <= '0;
    end else begin
      out_color <= next_color;
      out_hit   <= next_hit;
    end
  end

  assign bus.vga_red   = out_color[R_LSB +: CH_W];
  assign bus.vga_green = out_color[G_LSB +: CH_W];
  assign bus.vga_blue  = out_color[B_LSB +: CH_W];
  assign bus.layer_hit = out_hit;

endmodule

// File: tb/tb_layer_compositor.sv
// tb/tb_layer_compositor.sv - self-checking bench for layer_compositor
module tb_layer_compositor;
  import compositor_pkg::*;

  localparam int NL  = 2;
  localparam int CW  = 12;
  localparam int WW  = 2;
  localparam int BDW = 5;
  localparam int LW  = CW + 1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  layer_compositor_if #(.NUM_LAYERS(NL), .COLOR_W(CW), .WORLD_W(WW)) bus ();

  layer_compositor #(
    .NUM_LAYERS (NL),
    .COLOR_W    (CW),
    .WORLD_W    (WW),
    .BLINK_DIV_W(BDW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [CW-1:0] color;
    logic [NL-1:0] hit;
  } pix_t;

  typedef struct {
    logic             v;
    logic [WW-1:0]    w;
    logic [NL*LW-1:0] l;
    logic [CW-1:0]    bg;
    logic [CW-1:0]    exp_color;
    logic [NL-1:0]    exp_hit;
  } vec_t;

  int passed = 0;
  int total  = 0;

  pix_t  expq [$];
  string nameq[$];

  // Reference state: palette contents and number of frame_start pulses seen.
  logic [CW-1:0] mpal [4];
  int            mcnt;

  function automatic logic [NL*LW-1:0] lay(logic op1, logic [CW-1:0] c1,
                                            logic op0, logic [CW-1:0] c0);
    return {op1, c1, op0, c0};
  endfunction

  function automatic pix_t mk(logic [CW-1:0] c, logic [NL-1:0] h);
    pix_t p;
    p.color = c;
    p.hit   = h;
    return p;
  endfunction

  task automatic model_reset();
    mpal[0] = 12'h000;
    mpal[1] = 12'hC66;
    mpal[2] = 12'h1AD;
    mpal[3] = 12'h000;
    mcnt    = 0;
  endtask

  function automatic pix_t model(logic v, logic [WW-1:0] w, logic [NL*LW-1:0] l,
                                 logic [CW-1:0] bg, logic [NL-1:0] m);
    pix_t r;
    bit   phase;
    r = mk('0, '0);
    if (!v) return r;
`ifdef LAYER_COMPOSITOR_BLINK_EN
    phase = ((mcnt % 32) >= 16);
`else
    phase = 1'b0;
`endif
    for (int i = 0; i < NL; i++) begin
      logic [LW-1:0] word;
      word = LW'(l >> (i * LW));
      if (word[CW] && !(phase && m[i])) begin
        r.color = word[CW-1:0];
        r.hit   = NL'(1 << i);
        return r;
      end
    end
    r.color = (w == 0) ? bg : mpal[w];
    return r;
  endfunction

  task automatic check(string name, pix_t exp);
    logic [CW-1:0] act;
    act = {bus.vga_blue, bus.vga_green, bus.vga_red};
    total++;
    if (act === exp.color && bus.layer_hit === exp.hit) begin
      passed++;
    end else begin
      $display("FAIL %s: got color=%h hit=%b, want color=%h hit=%b",
               name, act, bus.layer_hit, exp.color, exp.hit);
    end
  endtask

  // One pixel per call; outputs are compared two calls later.
  task automatic step(string name, logic v, logic [WW-1:0] w, logic [NL*LW-1:0] l,
                      logic [CW-1:0] bg, logic we, logic [WW-1:0] a, logic [CW-1:0] d,
                      logic fs, logic [NL-1:0] m, bit use_model, pix_t exp);
    pix_t e;
    bus.video_on     = v;
    bus.world_pixel  = w;
    bus.layer_pixels = l;
    bus.bg_pixel     = bg;
    bus.pal_we       = we;
    bus.pal_addr     = a;
    bus.pal_wdata    = d;
    bus.frame_start  = fs;
    bus.blink_mask   = m;
    if (we) mpal[a] = d;
`ifdef LAYER_COMPOSITOR_BLINK_EN
    if (fs) mcnt++;
`endif
    e = use_model ? model(v, w, l, bg, m) : exp;
    expq.push_back(e);
    nameq.push_back(name);
    @(posedge clk);
    #1;
    if (expq.size() >= 2) check(nameq.pop_front(), expq.pop_front());
  endtask

  task automatic idle(int n, logic fs);
    for (int i = 0; i < n; i++) begin
      step("idle", 1'b0, '0, '0, '0, 1'b0, '0, '0, fs, '0, 1'b0, mk('0, '0));
    end
  endtask

  task automatic drive_idle_inputs();
    bus.video_on     = 1'b0;
    bus.world_pixel  = '0;
    bus.layer_pixels = '0;
    bus.bg_pixel     = '0;
    bus.pal_we       = 1'b0;
    bus.pal_addr     = '0;
    bus.pal_wdata    = '0;
    bus.frame_start  = 1'b1;
    bus.blink_mask   = '1;
  endtask

  vec_t tbl[8];

  initial begin
    pix_t zero;
    zero = mk('0, '0);

    tbl[0] = '{1'b1, 2'd1, lay(1'b0, 12'h000, 1'b0, 12'h000), 12'h000, 12'hC66, 2'b00};
    tbl[1] = '{1'b1, 2'd2, lay(1'b1, 12'h0F0, 1'b0, 12'h555), 12'h000, 12'h0F0, 2'b10};
    tbl[2] = '{1'b1, 2'd2, lay(1'b1, 12'h0F0, 1'b1, 12'h00E), 12'h000, 12'h00E, 2'b01};
    tbl[3] = '{1'b0, 2'd1, lay(1'b0, 12'h000, 1'b1, 12'hFFF), 12'h000, 12'h000, 2'b00};
    tbl[4] = '{1'b1, 2'd0, lay(1'b0, 12'hABC, 1'b0, 12'h321), 12'h4A7, 12'h4A7, 2'b00};
    tbl[5] = '{1'b1, 2'd3, lay(1'b0, 12'h000, 1'b0, 12'h000), 12'hFFF, 12'h000, 2'b00};
    tbl[6] = '{1'b1, 2'd2, lay(1'b0, 12'h000, 1'b0, 12'h000), 12'h000, 12'h1AD, 2'b00};
    tbl[7] = '{1'b1, 2'd0, lay(1'b1, 12'h123, 1'b0, 12'hEEE), 12'h777, 12'h123, 2'b10};

    // Reset, with frame_start held high to show it is ignored during reset.
    reset = 1'b1;
    drive_idle_inputs();
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", zero);
    reset = 1'b0;
    model_reset();

    // First pixel after reset: the output still shows the cleared stage 1.
    step("first_pixel", 1'b1, 2'd1, '0, '0, 1'b0, '0, '0, 1'b0, '0, 1'b0, mk(12'hC66, '0));
    check("latency_after_reset", zero);

    for (int i = 0; i < 8; i++) begin
      step($sformatf("vec%0d", i), tbl[i].v, tbl[i].w, tbl[i].l, tbl[i].bg,
           1'b0, '0, '0, 1'b0, '0, 1'b0, mk(tbl[i].exp_color, tbl[i].exp_hit));
    end
    idle(2, 1'b0);

    // Palette write in the same cycle stage 2 reads that entry returns the old colour.
    step("collide_old", 1'b1, 2'd1, '0, '0, 1'b0, '0, '0, 1'b0, '0, 1'b0, mk(12'hC66, '0));
    step("collide_new", 1'b1, 2'd1, '0, '0, 1'b1, 2'd1, 12'h123, 1'b0, '0, 1'b0, mk(12'h123, '0));
    step("after_write", 1'b1, 2'd1, '0, '0, 1'b0, '0, '0, 1'b0, '0, 1'b0, mk(12'h123, '0));
    idle(2, 1'b0);

    // Reset mid-stream: outputs zero on the next clock; palette defaults return.
    step("pre_reset", 1'b1, 2'd2, '0, '0, 1'b0, '0, '0, 1'b0, '0, 1'b0, mk(12'h1AD, '0));
    step("pre_reset", 1'b1, 2'd2, lay(1'b1, 12'hFFF, 1'b0, 12'h0), '0, 1'b0, '0, '0, 1'b0, '0, 1'b0, mk(12'hFFF, 2'b10));
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("mid_reset", zero);
    reset = 1'b0;
    model_reset();
    expq.delete();
    nameq.delete();
    step("post_reset_pal", 1'b1, 2'd1, '0, '0, 1'b0, '0, '0, 1'b0, '0, 1'b0, mk(12'hC66, '0));
    check("latency_mid_reset", zero);
    idle(2, 1'b0);

`ifdef LAYER_COMPOSITOR_BLINK_EN
    idle(16, 1'b1);
    step("blink_hidden", 1'b1, 2'd1, lay(1'b0, 12'h0, 1'b1, 12'h00E), '0, 1'b0, '0, '0,
         1'b0, 2'b01, 1'b0, mk(12'hC66, '0));
    step("blink_unmasked", 1'b1, 2'd1, lay(1'b1, 12'h0F0, 1'b1, 12'h00E), '0, 1'b0, '0, '0,
         1'b0, 2'b01, 1'b0, mk(12'h0F0, 2'b10));
    idle(16, 1'b1);
    step("blink_wrapped", 1'b1, 2'd1, lay(1'b0, 12'h0, 1'b1, 12'h00E), '0, 1'b0, '0, '0,
         1'b0, 2'b01, 1'b0, mk(12'h00E, 2'b01));
    idle(2, 1'b0);
`endif

    // Randomised traffic against the reference model.
    for (int i = 0; i < 300; i++) begin
      logic             v, we, fs;
      logic [WW-1:0]    w, a;
      logic [NL*LW-1:0] l;
      logic [CW-1:0]    bg, d;
      logic [NL-1:0]    m;
      v  = ($urandom_range(7, 0) != 0);
      w  = WW'($urandom_range(3, 0));
      l  = (NL*LW)'($urandom);
      bg = CW'($urandom);
      we = ($urandom_range(3, 0) == 0);
      a  = WW'($urandom_range(3, 0));
      d  = CW'($urandom);
      fs = ($urandom_range(3, 0) == 0);
      m  = NL'($urandom_range(3, 0));
      step("random", v, w, l, bg, we, a, d, fs, m, 1'b1, zero);
    end
    idle(2, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
